// File: rtl/eh2_posit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | eh2_posit_pkg: posit format defaults, constants and field struct    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package eh2_posit_pkg;

   localparam int POSIT_LEN_DEF   = 16;
   localparam int ES_DEF          = 2;
   localparam int REGIME_BW_DEF   = $clog2(POSIT_LEN_DEF);
   localparam int FRACTION_BW_DEF = POSIT_LEN_DEF - ES_DEF - 3;

   localparam logic [POSIT_LEN_DEF-1:0] MAXPOS = {1'b0, {(POSIT_LEN_DEF-1){1'b1}}};
   localparam logic [POSIT_LEN_DEF-1:0] MINPOS = {{(POSIT_LEN_DEF-1){1'b0}}, 1'b1};
   localparam logic [POSIT_LEN_DEF-1:0] NAR    = {1'b1, {(POSIT_LEN_DEF-1){1'b0}}};
   localparam logic [POSIT_LEN_DEF-1:0] ZERO   = '0;

   // Unpacked posit fields exchanged between the decoder and encoder sides.
   typedef struct packed {
      logic                          sign;
      logic signed [REGIME_BW_DEF:0] regime;
      logic [ES_DEF-1:0]             exponent;
      logic [FRACTION_BW_DEF-1:0]    fraction;
      logic                          round;
      logic                          sticky;
      logic                          is_zero;
      logic                          is_nar;
   } posit_fields_t;

endpackage : eh2_posit_pkg
`default_nettype wire

// File: rtl/eh2_posit_round.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | eh2_posit_round: round-to-nearest-even with saturation on magnitude  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module eh2_posit_round
   import eh2_posit_pkg::*;
#(
   parameter int POSIT_LEN = POSIT_LEN_DEF
) (
   input  logic [POSIT_LEN-2:0] i_body,
   input  logic                 i_guard,
   input  logic                 i_sticky,
   input  logic                 i_sat_max,
   input  logic                 i_sat_min,
   output logic [POSIT_LEN-2:0] o_mag
);

   localparam int BW = POSIT_LEN - 1;

   logic          w_inc;
   logic [BW:0]   w_sum;

   assign w_inc = i_guard & (i_body[0] | i_sticky);
   assign w_sum = {1'b0, i_body} + {{BW{1'b0}}, w_inc};

   // A nonzero value must never collapse to the zero encoding.
   always_comb begin
      o_mag = w_sum[BW-1:0];
      if (i_sat_max || w_sum[BW]) begin
         o_mag = {BW{1'b1}};
      end else if (i_sat_min || (w_sum[BW-1:0] == '0)) begin
         o_mag = {{(BW-1){1'b0}}, 1'b1};
      end
   end

endmodule : eh2_posit_round
`default_nettype wire

// File: rtl/eh2_posit_encode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | eh2_posit_encode: 2-stage posit packer (assemble, then round/sign)   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module eh2_posit_encode
   import eh2_posit_pkg::*;
#(
   parameter int POSIT_LEN   = POSIT_LEN_DEF,
   parameter int ES          = ES_DEF,
   parameter int REGIME_BW   = $clog2(POSIT_LEN),
   parameter int FRACTION_BW = POSIT_LEN - ES - 3
) (
   input  logic                        clk,
   input  logic                        rst_l,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        in_sign,
   input  logic signed [REGIME_BW:0]   in_regime,
   input  logic [ES-1:0]               in_exponent,
   input  logic [FRACTION_BW-1:0]      in_fraction,
   input  logic                        in_round,
   input  logic                        in_sticky,
   input  logic                        in_is_zero,
   input  logic                        in_is_nar,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [POSIT_LEN-1:0]        posit_data_out
);

   localparam int VW   = 2 * POSIT_LEN;
   localparam int BW   = POSIT_LEN - 1;
   localparam int KMAX = POSIT_LEN - 2;
   localparam int KMIN = -(POSIT_LEN - 1);
   localparam logic [POSIT_LEN-1:0] c_nar = {1'b1, {BW{1'b0}}};

   logic                 w_advance;
   int                   w_k;
   int                   w_shift;
   logic                 w_k_neg;
   logic [VW-1:0]        w_term_vec;
   logic [VW-1:0]        w_run_vec;
   logic [VW-1:0]        w_vec;
   logic [BW-1:0]        w_body;
   logic                 w_guard;
   logic                 w_sticky;
   logic                 w_sat_max;
   logic                 w_sat_min;

   logic                 r_s1_valid;
   logic [BW-1:0]        r_s1_body;
   logic                 r_s1_guard;
   logic                 r_s1_sticky;
   logic                 r_s1_sign;
   logic                 r_s1_zero;
   logic                 r_s1_nar;
   logic                 r_s1_sat_max;
   logic                 r_s1_sat_min;

   logic [BW-1:0]        w_mag;
   logic [POSIT_LEN-1:0] w_signed_mag;
   logic [POSIT_LEN-1:0] w_result;

   logic                 r_out_valid;
   logic [POSIT_LEN-1:0] r_out_data;

   assign w_advance      = ~r_out_valid | out_ready;
   assign in_ready       = w_advance;
   assign out_valid      = r_out_valid;
   assign posit_data_out = r_out_data;

   // Stage 1: regime run is formed as a shifted ones-mask (k >= 0 only), and the
   // terminator plus exponent/fraction/round tail is shifted in behind it.
   always_comb begin
      w_k        = int'(in_regime);
      w_k_neg    = in_regime[REGIME_BW];
      w_shift    = w_k_neg ? -w_k : (w_k + 1);
      w_term_vec = {w_k_neg, in_exponent, in_fraction, in_round, {(POSIT_LEN+1){1'b0}}};
      w_run_vec  = w_k_neg ? '0 : ~({VW{1'b1}} >> w_shift);
      w_vec      = w_run_vec | (w_term_vec >> w_shift);
      w_body     = w_vec[VW-1 -: BW];
      w_guard    = w_vec[POSIT_LEN];
      w_sticky   = (|w_vec[POSIT_LEN-1:0]) | in_sticky;
      w_sat_max  = (w_k >= KMAX);
      w_sat_min  = (w_k <= KMIN);
   end

   eh2_posit_round #(
      .POSIT_LEN (POSIT_LEN)
   ) u_round (
      .i_body    (r_s1_body),
      .i_guard   (r_s1_guard),
      .i_sticky  (r_s1_sticky),
      .i_sat_max (r_s1_sat_max),
      .i_sat_min (r_s1_sat_min),
      .o_mag     (w_mag)
   );

   always_comb begin
      w_signed_mag = {1'b0, w_mag};
      w_result     = w_signed_mag;
      if (r_s1_nar) begin
         w_result = c_nar;
      end else if (r_s1_zero) begin
         w_result = '0;
      end else if (r_s1_sign) begin
         w_result = ~w_signed_mag + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         r_s1_valid   <= 1'b0;
         r_s1_body    <= '0;
         r_s1_guard   <= 1'b0;
         r_s1_sticky  <= 1'b0;
         r_s1_sign    <= 1'b0;
         r_s1_zero    <= 1'b0;
         r_s1_nar     <= 1'b0;
         r_s1_sat_max <= 1'b0;
         r_s1_sat_min <= 1'b0;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
      end else if (w_advance) begin
         r_s1_valid  <= in_valid;
         if (in_valid) begin
            r_s1_body    <= w_body;
            r_s1_guard   <= w_guard;
            r_s1_sticky  <= w_sticky;
            r_s1_sign    <= in_sign;
            r_s1_zero    <= in_is_zero;
            r_s1_nar     <= in_is_nar;
            r_s1_sat_max <= w_sat_max;
            r_s1_sat_min <= w_sat_min;
         end
         r_out_valid <= r_s1_valid;
         r_out_data  <= r_s1_valid ? w_result : '0;
      end
   end

endmodule : eh2_posit_encode
`default_nettype wire

// File: tb/tb_eh2_posit_encode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_eh2_posit_encode: scoreboard bench for the posit encoder          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_eh2_posit_encode;

   localparam int N    = 16;
   localparam int ES   = 2;
   localparam int FBW  = N - ES - 3;

   logic              clk = 1'b0;
   logic              rst_l;
   logic              in_valid;
   logic              in_ready;
   logic              in_sign;
   logic signed [4:0] in_regime;
   logic [ES-1:0]     in_exponent;
   logic [FBW-1:0]    in_fraction;
   logic              in_round;
   logic              in_sticky;
   logic              in_is_zero;
   logic              in_is_nar;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [N-1:0]      posit_data_out;

   int                checks = 0;
   int                errors = 0;
   logic [N-1:0]      exp_q[$];
   bit                ready_mode  = 1'b0;
   bit                force_ready = 1'b1;

   eh2_posit_encode dut (
      .clk            (clk),
      .rst_l          (rst_l),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_sign        (in_sign),
      .in_regime      (in_regime),
      .in_exponent    (in_exponent),
      .in_fraction    (in_fraction),
      .in_round       (in_round),
      .in_sticky      (in_sticky),
      .in_is_zero     (in_is_zero),
      .in_is_nar      (in_is_nar),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .posit_data_out (posit_data_out)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      out_ready = ready_mode ? ($urandom_range(0, 3) != 0) : force_ready;
   end

   // Reference: write the posit bit string out one bit at a time, then round.
   function automatic logic [N-1:0] ref_encode(input bit s, input int k, input int e,
                                               input int f, input bit r, input bit st,
                                               input bit z, input bit n);
      bit bits[$];
      int body = 0;
      int nb   = 0;
      bit g    = 1'b0;
      bit stk  = st;
      int mag;
      if (n) return 16'h8000;
      if (z) return 16'h0000;
      if (k >= N - 2) mag = (1 << (N - 1)) - 1;
      else if (k <= -(N - 1)) mag = 1;
      else begin
         if (k >= 0) begin
            repeat (k + 1) bits.push_back(1'b1);
            bits.push_back(1'b0);
         end else begin
            repeat (-k) bits.push_back(1'b0);
            bits.push_back(1'b1);
         end
         for (int i = ES - 1; i >= 0; i--) bits.push_back(bit'((e >> i) & 1));
         for (int i = FBW - 1; i >= 0; i--) bits.push_back(bit'((f >> i) & 1));
         bits.push_back(r);
         foreach (bits[i]) begin
            if (i < N - 1) begin body = body * 2 + int'(bits[i]); nb++; end
            else if (i == N - 1) g = bits[i];
            else stk = stk | bits[i];
         end
         body = body << (N - 1 - nb);
         if (g && ((body % 2) == 1 || stk)) body = body + 1;
         if (body >= (1 << (N - 1))) body = (1 << (N - 1)) - 1;
         if (body == 0) body = 1;
         mag = body;
      end
      return s ? N'((1 << N) - mag) : N'(mag);
   endfunction

   task automatic drive(input bit s, input int k, input int e, input int f,
                        input bit r, input bit st, input bit z, input bit n);
      in_valid    = 1'b1;
      in_sign     = s;
      in_regime   = 5'(k);
      in_exponent = ES'(e);
      in_fraction = FBW'(f);
      in_round    = r;
      in_sticky   = st;
      in_is_zero  = z;
      in_is_nar   = n;
   endtask

   task automatic send(input bit s, input int k, input int e, input int f, input bit r,
                       input bit st, input bit z, input bit n, input logic [N-1:0] exp);
      int waited = 0;
      @(negedge clk);
      drive(s, k, e, f, r, st, z, n);
      #1;
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL in_ready_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waited);
      end else begin
         exp_q.push_back(exp);
      end
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_empty();
      int waited = 0;
      while (exp_q.size() != 0 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      end
   endtask

   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%04h, required 0x%04h", name, act, req);
      end
   endtask

   // Monitor: pops the scoreboard on each output transfer and enforces stall hold.
   logic         prev_stall = 1'b0;
   logic [N-1:0] prev_data  = '0;
   always @(negedge clk) begin
      logic [N-1:0] e;
      #2;
      if (!rst_l) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            checks++;
            if (!out_valid || posit_data_out !== prev_data) begin
               errors++;
               $display("FAIL stall_hold: out_valid=%0b data=0x%04h, required 1/0x%04h",
                        out_valid, posit_data_out, prev_data);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output: got 0x%04h, required no output", posit_data_out);
            end else begin
               e = exp_q.pop_front();
               if (posit_data_out !== e) begin
                  errors++;
                  $display("FAIL output: got 0x%04h, required 0x%04h", posit_data_out, e);
               end
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = posit_data_out;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [N-1:0] bp_exp [3] = '{16'h4000, 16'h6000, 16'h7000};

   initial begin
      int accepted;
      rst_l = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_l = 1'b1;
      @(negedge clk);
      #1;
      check("reset_out_valid", N'(out_valid), 16'h0000);
      check("reset_data", posit_data_out, 16'h0000);
      check("reset_in_ready", N'(in_ready), 16'h0001);

      // Directed values, back to back.
      send(0,   0, 0, 0,     0, 0, 0, 0, 16'h4000);
      send(1,   0, 0, 0,     0, 0, 0, 0, 16'hC000);
      send(0,   1, 1, 0,     0, 0, 0, 0, 16'h6400);
      send(0,  -1, 0, 0,     0, 0, 0, 0, 16'h2000);
      send(0,   0, 0, 11'h7FF, 1, 0, 0, 0, 16'h4800);
      send(0,   0, 0, 0,     1, 0, 0, 0, 16'h4000);
      send(0,   0, 0, 0,     1, 1, 0, 0, 16'h4001);
      send(0,  13, 0, 0,     0, 0, 0, 0, 16'h7FFE);
      send(0,  14, 0, 0,     0, 0, 0, 0, 16'h7FFF);
      send(0,  15, 3, 11'h7FF, 1, 1, 0, 0, 16'h7FFF);
      send(0, -14, 3, 0,     0, 0, 0, 0, 16'h0002);
      send(0, -15, 0, 0,     0, 0, 0, 0, 16'h0001);
      send(1, -16, 0, 0,     0, 0, 0, 0, 16'hFFFF);
      send(1,   3, 2, 5,     1, 1, 1, 1, 16'h8000);
      send(1,   3, 2, 5,     1, 1, 1, 0, 16'h0000);
      idle();
      wait_empty();

      // Backpressure: only two transactions fit while the consumer stalls.
      @(posedge clk);
      force_ready = 1'b0;
      accepted = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         drive(0, accepted, 0, 0, 0, 0, 0, 0);
         #1;
         if (in_ready) begin
            exp_q.push_back(bp_exp[accepted]);
            accepted++;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("bp_accepted", N'(accepted), 16'h0002);
      check("bp_in_ready", N'(in_ready), 16'h0000);
      check("bp_out_valid", N'(out_valid), 16'h0001);
      check("bp_head", posit_data_out, bp_exp[0]);
      @(posedge clk);
      force_ready = 1'b1;
      wait_empty();

      // Reset with two results in flight.
      @(posedge clk);
      force_ready = 1'b0;
      send(0, 2, 1, 3, 0, 0, 0, 0, ref_encode(0, 2, 1, 3, 0, 0, 0, 0));
      send(1, 4, 2, 9, 0, 0, 0, 0, ref_encode(1, 4, 2, 9, 0, 0, 0, 0));
      @(negedge clk);
      in_valid = 1'b0;
      rst_l    = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1;
      check("rst_mid_out_valid", N'(out_valid), 16'h0000);
      check("rst_mid_data", posit_data_out, 16'h0000);
      @(negedge clk);
      rst_l = 1'b1;
      @(posedge clk);
      force_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         #3;
         check("rst_no_stale", N'(out_valid), 16'h0000);
      end

      // Randomized traffic with random consumer stalls.
      @(posedge clk);
      ready_mode = 1'b1;
      for (int t = 0; t < 300; t++) begin
         bit s, r, st, z, n;
         int k, e, f;
         s  = bit'($urandom_range(0, 1));
         k  = int'($urandom_range(0, 31));
         if (k >= 16) k = k - 32;
         e  = int'($urandom_range(0, 3));
         f  = int'($urandom_range(0, 2047));
         r  = bit'($urandom_range(0, 1));
         st = bit'($urandom_range(0, 1));
         z  = ($urandom_range(0, 15) == 0);
         n  = ($urandom_range(0, 15) == 0);
         send(s, k, e, f, r, st, z, n, ref_encode(s, k, e, f, r, st, z, n));
         if ($urandom_range(0, 3) == 0) idle();
      end
      idle();
      @(posedge clk);
      ready_mode = 1'b0;
      wait_empty();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule : tb_eh2_posit_encode
`default_nettype wire
